// File: rtl/sync_down_counter.sv
// sync_down_counter: synchronous down counter with a loadable reload value.
// It works as a programmable interval timer or an event down-counter.
// Every state change happens on the rising edge of clk. Reset is the exception.
//
// Ports:
//   clk       - system clock; all state updates on the rising edge
//   rst       - asynchronous, active-high reset
//   t         - count enable; decrement on a clk edge when high
//   load      - synchronous load strobe; writes din to count and reload
//   din       - load value
//   q         - current count (registered)
//   zero      - combinational, q == 0
//   tc        - combinational terminal count, for cascading a higher stage's t
//   underflow - registered one-cycle pulse, high after a counted underflow
//   done      - registered; high in DONE state (ONESHOT=1 only, else 0)
//
// Parameters:
//   WIDTH   - counter and reload width in bits
//   ONESHOT - 0: auto-reload on underflow; 1: park at zero in DONE until load

module sync_down_counter #(
    parameter int unsigned WIDTH   = 4,
    parameter int unsigned ONESHOT = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             t,
    input  logic             load,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] q,
    output logic             zero,
    output logic             tc,
    output logic             underflow,
    output logic             done
);

    localparam logic ONESHOT_EN = (ONESHOT != 0);

    typedef enum logic {
        COUNTING = 1'b0,
        DONE_ST  = 1'b1
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] count;
    logic [WIDTH-1:0] reload;
    logic             underflow_r;
    logic             done_r;

    // Counter, reload register, and COUNTING/DONE state machine.
    // The underflow pulse defaults low every cycle unless the count wraps.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count       <= '1;
            reload      <= '1;
            underflow_r <= 1'b0;
            done_r      <= 1'b0;
            state       <= COUNTING;
        end else if (load) begin
            // Load beats a concurrent count or underflow.
            count       <= din;
            reload      <= din;
            underflow_r <= 1'b0;
            done_r      <= 1'b0;
            state       <= COUNTING;
        end else begin
            underflow_r <= 1'b0;
            case (state)
                COUNTING: begin
                    if (t) begin
                        if (count != '0) begin
                            count <= count - WIDTH'(1);
                        end else begin
                            underflow_r <= 1'b1;
                            if (ONESHOT_EN) begin
                                state  <= DONE_ST;
                                done_r <= 1'b1;
                            end else begin
                                count <= reload;
                            end
                        end
                    end
                end
                DONE_ST: begin
                    // Parked: t is ignored; only load or rst can leave this state.
                    count  <= '0;
                    done_r <= 1'b1;
                end
                default: begin
                    state <= COUNTING;
                end
            endcase
        end
    end

    assign q         = count;
    assign underflow = underflow_r;
    assign done      = ONESHOT_EN ? done_r : 1'b0;
    assign zero      = (count == '0);
    // Gating with done stops a parked one-shot from driving a cascaded stage.
    assign tc        = zero && t && !done;

endmodule

// File: tb/tb_sync_down_counter.sv
// Self-checking bench for sync_down_counter.
// It runs one periodic instance and one one-shot instance (WIDTH=4).
// Both instances share the same inputs.
// Expected results go into a scoreboard queue when stimulus is driven.
// They are popped and compared one time unit after the next rising edge.

module tb_sync_down_counter;

    logic       clk = 1'b0;
    logic       rst;
    logic       t;
    logic       load;
    logic [3:0] din;

    logic [3:0] q_p, q_o;
    logic       zero_p, zero_o, tc_p, tc_o, uf_p, uf_o, done_p, done_o;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct packed {
        logic [3:0] q;
        logic       uf;
        logic       done;
        logic       tc;
    } exp_t;

    typedef struct {
        logic       t;
        logic       load;
        logic [3:0] din;
        logic [3:0] q;
        logic       uf;
    } vec_t;

    exp_t sb[$];
    vec_t vecs[$];

    sync_down_counter #(.WIDTH(4), .ONESHOT(0)) dut_p (
        .clk(clk), .rst(rst), .t(t), .load(load), .din(din),
        .q(q_p), .zero(zero_p), .tc(tc_p), .underflow(uf_p), .done(done_p)
    );

    sync_down_counter #(.WIDTH(4), .ONESHOT(1)) dut_o (
        .clk(clk), .rst(rst), .t(t), .load(load), .din(din),
        .q(q_o), .zero(zero_o), .tc(tc_o), .underflow(uf_o), .done(done_o)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: test did not finish within time limit");
        $fatal(1, "timeout");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void add(input logic t_i, input logic load_i, input logic [3:0] din_i,
                                input logic [3:0] q_i, input logic uf_i);
        vec_t v;
        v.t = t_i; v.load = load_i; v.din = din_i; v.q = q_i; v.uf = uf_i;
        vecs.push_back(v);
    endfunction

    // One clock of stimulus on the selected instance (0: periodic, 1: one-shot).
    task automatic step(input bit sel, input logic t_i, input logic load_i, input logic [3:0] din_i,
                        input logic [3:0] exp_q, input logic exp_uf, input logic exp_done);
        exp_t e;
        @(negedge clk);
        t = t_i; load = load_i; din = din_i;
        e.q = exp_q; e.uf = exp_uf; e.done = exp_done;
        e.tc = (exp_q == 4'd0) && t_i && !exp_done;
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        if (sel) begin
            check("os_q", 32'(q_o), 32'(e.q));
            check("os_underflow", 32'(uf_o), 32'(e.uf));
            check("os_done", 32'(done_o), 32'(e.done));
            check("os_zero", 32'(zero_o), 32'(e.q == 4'd0));
            check("os_tc", 32'(tc_o), 32'(e.tc));
        end else begin
            check("per_q", 32'(q_p), 32'(e.q));
            check("per_underflow", 32'(uf_p), 32'(e.uf));
            check("per_done", 32'(done_p), 32'(e.done));
            check("per_zero", 32'(zero_p), 32'(e.q == 4'd0));
            check("per_tc", 32'(tc_p), 32'(e.tc));
        end
    endtask

    // Asynchronous reset in mid-cycle; outputs must settle before any clock edge.
    task automatic async_reset(input string tag);
        #2;
        rst = 1'b1;
        #1;
        check({tag, "_per_q"}, 32'(q_p), 32'hF);
        check({tag, "_per_underflow"}, 32'(uf_p), 32'd0);
        check({tag, "_per_zero"}, 32'(zero_p), 32'd0);
        check({tag, "_os_q"}, 32'(q_o), 32'hF);
        check({tag, "_os_done"}, 32'(done_o), 32'd0);
        check({tag, "_os_underflow"}, 32'(uf_o), 32'd0);
        @(negedge clk);
        t = 1'b0; load = 1'b0; din = 4'd0;
        rst = 1'b0;
    endtask

    initial begin
        // Free-run wrap from reset: F -> 0 in 15 steps, then reload F, then E.
        for (int i = 1; i <= 15; i++) add(1'b1, 1'b0, 4'd0, 4'(15 - i), 1'b0);
        add(1'b1, 1'b0, 4'd0, 4'hF, 1'b1);
        add(1'b1, 1'b0, 4'd0, 4'hE, 1'b0);
        // Load 3: period of 4, with t dropped for two cycles in mid-count.
        add(1'b0, 1'b1, 4'd3, 4'd3, 1'b0);
        add(1'b1, 1'b0, 4'd0, 4'd2, 1'b0);
        add(1'b1, 1'b0, 4'd0, 4'd1, 1'b0);
        add(1'b1, 1'b0, 4'd0, 4'd0, 1'b0);
        add(1'b1, 1'b0, 4'd0, 4'd3, 1'b1);
        add(1'b1, 1'b0, 4'd0, 4'd2, 1'b0);
        add(1'b0, 1'b0, 4'd0, 4'd2, 1'b0);
        add(1'b0, 1'b0, 4'd0, 4'd2, 1'b0);
        add(1'b1, 1'b0, 4'd0, 4'd1, 1'b0);
        add(1'b1, 1'b0, 4'd0, 4'd0, 1'b0);
        add(1'b1, 1'b0, 4'd0, 4'd3, 1'b1);
        add(1'b1, 1'b0, 4'd0, 4'd2, 1'b0);
        add(1'b1, 1'b0, 4'd0, 4'd1, 1'b0);
        add(1'b1, 1'b0, 4'd0, 4'd0, 1'b0);
        // Load collides with underflow: load wins, and the reload becomes 9.
        add(1'b1, 1'b1, 4'd9, 4'd9, 1'b0);
        for (int i = 1; i <= 9; i++) add(1'b1, 1'b0, 4'd0, 4'(9 - i), 1'b0);
        add(1'b1, 1'b0, 4'd0, 4'd9, 1'b1);
        // Reload value of 0: underflow fires on every enabled cycle.
        add(1'b0, 1'b1, 4'd0, 4'd0, 1'b0);
        add(1'b1, 1'b0, 4'd0, 4'd0, 1'b1);
        add(1'b1, 1'b0, 4'd0, 4'd0, 1'b1);
        add(1'b1, 1'b0, 4'd0, 4'd0, 1'b1);
        add(1'b0, 1'b0, 4'd0, 4'd0, 1'b0);

        rst = 1'b1; t = 1'b0; load = 1'b0; din = 4'd0;
        #2;
        check("reset_per_q", 32'(q_p), 32'hF);
        check("reset_per_zero", 32'(zero_p), 32'd0);
        check("reset_per_underflow", 32'(uf_p), 32'd0);
        check("reset_per_done", 32'(done_p), 32'd0);
        check("reset_os_q", 32'(q_o), 32'hF);
        check("reset_os_done", 32'(done_o), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Periodic instance: table-driven vectors.
        foreach (vecs[i]) step(1'b0, vecs[i].t, vecs[i].load, vecs[i].din, vecs[i].q, vecs[i].uf, 1'b0);

        // One-shot: load 2, count to zero, park in DONE, then reload with 5.
        step(1'b1, 1'b0, 1'b1, 4'd2, 4'd2, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 4'd0, 4'd1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 4'd0, 4'd0, 1'b1, 1'b1);
        for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 1'b0, 4'd0, 4'd0, 1'b0, 1'b1);
        step(1'b1, 1'b1, 1'b1, 4'd5, 4'd5, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 4'd0, 4'd4, 1'b0, 1'b0);

        // Reset while done=1 with an underflow pulse pending on both instances.
        step(1'b1, 1'b0, 1'b1, 4'd0, 4'd0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 4'd0, 4'd0, 1'b1, 1'b1);
        async_reset("rst_done");

        // Reset in mid-count at q=6, then resume counting normally.
        step(1'b0, 1'b0, 1'b1, 4'd6, 4'd6, 1'b0, 1'b0);
        async_reset("rst_mid");
        step(1'b0, 1'b1, 1'b0, 4'd0, 4'hE, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 4'd0, 4'hD, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
